ntt_arbiter: RTL and testbench

NTT_ARBITER -- requirements
Module: ntt_arbiter

---
 rtl/ntt_arbiter.sv | 142 ++++++++++++++
 tb/tb_ntt_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_arbiter.sv
// ntt_arbiter: two-requester round-robin front end for a single parallel NTT
// engine. Jobs go through IDLE -> RUN -> RESP -> GAP. The GAP cycle holds
// ntt_start low so the engine re-arms between jobs.
// Optional feature: define NTT_ARB_TIMEOUT_EN to abort a job after
// TIMEOUT_CYCLES RUN cycles without ntt_done (resp_err flags the aborted job).
//
// Handshake: a requester holds reqN_valid while it has a polynomial pending.
// reqN_ready is combinational and high only in IDLE for the granted
// requester. A transfer happens on the rising edge where valid and ready are
// both high. Dropping valid without a transfer is legal and latches nothing.
module ntt_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req1_valid,
  input  logic [0:8191] req0_data,
  input  logic [0:8191] req1_data,
  output logic          req0_ready,
  output logic          req1_ready,
  output logic          req0_done,
  output logic          req1_done,
  output logic [0:8191] resp_data,
  output logic          resp_err,
  output logic          ntt_start,
  output logic [0:8191] ntt_inp,
  input  logic          ntt_done,
  input  logic [0:8191] ntt_out,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t state;
  logic   rr;      // requester that wins when both are valid
  logic   id;      // requester owning the job in flight
  logic   gnt1;    // grant target: 1 selects requester 1
  logic   hs0;
  logic   hs1;

`ifdef NTT_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;
  assign resp_err = err_q;
`else
  localparam int tmo_unused = TIMEOUT_CYCLES;
  assign resp_err = 1'b0;
`endif

  // Grant selection: a lone valid requester always wins; rr breaks ties.
  always_comb begin
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt1 = rr;
    end else begin
      gnt1 = req1_valid;
    end
  end

  assign req0_ready = (state == S_IDLE) && req0_valid && !gnt1;
  assign req1_ready = (state == S_IDLE) && req1_valid && gnt1;
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

  // Job sequencer: grant, run the engine, publish the result, re-arm gap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      rr        <= 1'b0;
      id        <= 1'b0;
      ntt_start <= 1'b0;
      ntt_inp   <= '0;
      resp_data <= '0;
      req0_done <= 1'b0;
      req1_done <= 1'b0;
`ifdef NTT_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs0 || hs1) begin
            ntt_inp   <= hs1 ? req1_data : req0_data;
            id        <= hs1;
            rr        <= hs0;
            ntt_start <= 1'b1;
            state     <= S_RUN;
`ifdef NTT_ARB_TIMEOUT_EN
            tmo_cnt   <= '0;
            err_q     <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (ntt_done) begin
            resp_data <= ntt_out;
            ntt_start <= 1'b0;
            req0_done <= !id;
            req1_done <= id;
            state     <= S_RESP;
          end
`ifdef NTT_ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            // Abort: result register keeps its previous contents.
            ntt_start <= 1'b0;
            err_q     <= 1'b1;
            req0_done <= !id;
            req1_done <= id;
            state     <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        S_RESP: begin
          state <= S_GAP;
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_arbiter.sv
// Bench for ntt_arbiter: engine model with programmable latency
// (out = inp + 1 per coefficient), negedge monitor feeding a scoreboard,
// one task per scenario, summary line at the end.
`timescale 1ns/1ps
module tb_ntt_arbiter;

  localparam int TMO = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          req0_valid = 1'b0;
  logic          req1_valid = 1'b0;
  logic [0:8191] req0_data = '0;
  logic [0:8191] req1_data = '0;
  logic          req0_ready, req1_ready, req0_done, req1_done;
  logic [0:8191] resp_data;
  logic          resp_err;
  logic          ntt_start;
  logic [0:8191] ntt_inp;
  logic          ntt_done;
  logic [0:8191] ntt_out;
  logic          busy;
  logic [1:0]    state_dbg;

  ntt_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_done(req0_done), .req1_done(req1_done),
    .resp_data(resp_data), .resp_err(resp_err),
    .ntt_start(ntt_start), .ntt_inp(ntt_inp),
    .ntt_done(ntt_done), .ntt_out(ntt_out),
    .busy(busy), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [0:8191] plus_one(input logic [0:8191] d);
    logic [0:8191] r;
    for (int i = 0; i < 256; i++) r[i*32 +: 32] = d[i*32 +: 32] + 32'd1;
    return r;
  endfunction

  function automatic logic [0:8191] rand_poly();
    logic [0:8191] r;
    for (int i = 0; i < 256; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // engine model
  int eng_cnt = 0;
  int eng_lat = 10;
  bit eng_en = 1'b1;
  bit force_done = 1'b0;
  always @(posedge clock) begin
    if (!ntt_start) eng_cnt <= 0;
    else eng_cnt <= eng_cnt + 1;
  end
  assign ntt_done = force_done || (eng_en && ntt_start && (eng_cnt == eng_lat - 1));
  always_comb ntt_out = plus_one(ntt_inp);

  // scoreboard and monitor
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [0:8191] exp_q[$];
  logic          exp_id_q[$];
  logic [0:8191] obs_q[$];
  logic          obs_id_q[$];
  logic          obs_err_q[$];
  int            grant_q[$];
  int            hs_edge_q[$];
  int            done_edge_q[$];
  int            pulse_cyc_q[$];
  int done0_cnt, done1_cnt, start_cycles, ready0_cycles, both_done;
  logic [0:8191] last_exp = '0;

  always @(negedge clock) begin
    if (req0_done) done0_cnt++;
    if (req1_done) done1_cnt++;
    if (req0_done && req1_done) both_done++;
    if (reset) begin
      exp_q.delete();
      exp_id_q.delete();
    end else begin
      if (req0_ready) ready0_cycles++;
      if (ntt_start) start_cycles++;
      if (req0_valid && req0_ready) begin
        exp_q.push_back(plus_one(req0_data)); exp_id_q.push_back(1'b0);
        grant_q.push_back(0); hs_edge_q.push_back(cyc + 1);
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back(plus_one(req1_data)); exp_id_q.push_back(1'b1);
        grant_q.push_back(1); hs_edge_q.push_back(cyc + 1);
      end
      if (ntt_done && ntt_start) done_edge_q.push_back(cyc + 1);
      if (req0_done || req1_done) begin
        obs_q.push_back(resp_data);
        obs_id_q.push_back(req1_done);
        obs_err_q.push_back(resp_err);
        pulse_cyc_q.push_back(cyc + 1);
      end
    end
  end

  // driver tasks
  task automatic clear_stats();
    exp_q.delete(); exp_id_q.delete(); obs_q.delete(); obs_id_q.delete();
    obs_err_q.delete(); grant_q.delete(); hs_edge_q.delete();
    done_edge_q.delete(); pulse_cyc_q.delete();
    done0_cnt = 0; done1_cnt = 0; start_cycles = 0; ready0_cycles = 0; both_done = 0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Hold the chosen valids until n done pulses; fresh data after each accept.
  task automatic run_jobs(input int n, input bit v0, input bit v1, input int budget, output bit ok);
    bit h0, h1;
    ok = 1'b0;
    req0_valid = v0; req1_valid = v1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock); #1;
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (done0_cnt + done1_cnt >= n) begin ok = 1'b1; break; end
      @(posedge clock); #1;
      if (h0) req0_data = rand_poly();
      if (h1) req1_data = rand_poly();
    end
    @(posedge clock); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  // Pop one scoreboard entry and compare it with the next observed result.
  task automatic pop_check(input string name, input logic exp_err);
    logic [0:8191] e;
    checks++;
    if (exp_q.size() == 0 || obs_q.size() == 0) begin
      errors++;
      $display("FAIL %s: missing entry exp=%0d obs=%0d required >=1 each", name, exp_q.size(), obs_q.size());
    end else begin
      e = exp_q.pop_front();
      if (obs_id_q[0] !== exp_id_q[0] || obs_err_q[0] !== exp_err ||
          (!exp_err && obs_q[0] !== e) || (exp_err && obs_q[0] !== last_exp)) begin
        errors++;
        $display("FAIL %s: id=%0d err=%0d required id=%0d err=%0d (data equal=%0d)", name,
                 obs_id_q[0], obs_err_q[0], exp_id_q[0], exp_err,
                 exp_err ? (obs_q[0] === last_exp) : (obs_q[0] === e));
      end
      if (!exp_err) last_exp = e;
      void'(exp_id_q.pop_front()); void'(obs_q.pop_front());
      void'(obs_id_q.pop_front()); void'(obs_err_q.pop_front());
    end
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, ntt_start, req0_done, req1_done, resp_err, req0_ready, req1_ready} !== 7'b0 ||
        ntt_inp !== '0 || resp_data !== '0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b start=%0b done=%0b%0b err=%0b state=%0d required all 0",
               busy, ntt_start, req0_done, req1_done, resp_err, state_dbg);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%0b state=%0d required 0/0", busy, state_dbg);
    end
  endtask

  task automatic test_single();
    logic [0:8191] want;
    bit ok;
    clear_stats();
    for (int i = 0; i < 256; i++) begin
      req0_data[i*32 +: 32] = 32'(i + 1);
      want[i*32 +: 32] = 32'(i + 2);
    end
    run_jobs(1, 1'b1, 1'b0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: no done within budget, required 1 done"); end
    checks++;
    if (obs_q.size() == 0 || obs_q[0] !== want) begin
      errors++; $display("FAIL single_data: coeff0=%0d required 2", obs_q.size() ? obs_q[0][0:31] : 0);
    end
    checks++;
    if (ready0_cycles != 1) begin errors++; $display("FAIL single_ready: %0d cycles required 1", ready0_cycles); end
    checks++;
    if (start_cycles != 10) begin errors++; $display("FAIL single_start: %0d cycles required 10", start_cycles); end
    checks++;
    if (done0_cnt != 1 || done1_cnt != 0) begin
      errors++; $display("FAIL single_dones: d0=%0d d1=%0d required 1/0", done0_cnt, done1_cnt);
    end
    checks++;
    if (done_edge_q.size() == 0 || pulse_cyc_q.size() == 0 || pulse_cyc_q[0] != done_edge_q[0] + 1) begin
      errors++; $display("FAIL single_latency: done pulse not in cycle after ntt_done edge");
    end
    pop_check("single_sb", 1'b0);
    repeat (5) @(posedge clock); #1;
    checks++;
    if (done1_cnt != 0 || done0_cnt != 1) begin
      errors++; $display("FAIL single_extra_done: d0=%0d d1=%0d required 1/0", done0_cnt, done1_cnt);
    end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    clear_stats();
    req0_data = rand_poly(); req1_data = rand_poly();
    run_jobs(2, 1'b1, 1'b1, 100, ok);
    checks++;
    if (!ok || grant_q.size() < 2 || grant_q[0] != 0 || grant_q[1] != 1) begin
      errors++; $display("FAIL contention_order: ok=%0d grants=%0d required 0 then 1", ok, grant_q.size());
    end
    checks++;
    if (hs_edge_q.size() < 2 || done_edge_q.size() < 1 || hs_edge_q[1] != done_edge_q[0] + 3) begin
      errors++; $display("FAIL contention_d3: req1 accept edge not d+3");
    end
    pop_check("contention_sb0", 1'b0);
    pop_check("contention_sb1", 1'b0);
  endtask

  task automatic test_fairness();
    bit ok;
    int want;
    clear_stats();
    do_reset();
    clear_stats();
    run_jobs(6, 1'b1, 1'b1, 200, ok);
    checks++;
    if (!ok || grant_q.size() != 6) begin
      errors++; $display("FAIL fair_count: ok=%0d grants=%0d required 6", ok, grant_q.size());
    end
    for (int k = 0; k < grant_q.size(); k++) begin
      want = k % 2;
      checks++;
      if (grant_q[k] != want) begin errors++; $display("FAIL fair_grant%0d: %0d required %0d", k, grant_q[k], want); end
    end
    for (int k = 0; k < 6; k++) pop_check("fair_sb", 1'b0);
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_stats();
    req1_data = rand_poly();
    run_jobs(3, 1'b0, 1'b1, 150, ok);
    checks++;
    if (!ok || done1_cnt != 3 || done0_cnt != 0) begin
      errors++; $display("FAIL b2b_lone: d1=%0d d0=%0d required 3/0", done1_cnt, done0_cnt);
    end
    for (int k = 0; k < 3; k++) pop_check("b2b_sb", 1'b0);
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    do_reset();
    clear_stats();
    req0_data = rand_poly();
    req0_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clock); #1;
      ok = req0_ready;
    end
    @(posedge clock); #1;
    req0_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || ntt_start !== 1'b0 || ntt_inp !== '0 || resp_data !== '0 ||
        resp_err !== 1'b0 || req0_done !== 1'b0 || req1_done !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: busy=%0b start=%0b required 0 with zero data", busy, ntt_start);
    end
    reset = 1'b0;
    last_exp = '0;
    repeat (20) @(posedge clock); #1;
    checks++;
    if (done0_cnt != 0 || done1_cnt != 0) begin
      errors++; $display("FAIL midrun_no_done: d0=%0d d1=%0d required 0/0", done0_cnt, done1_cnt);
    end
    clear_stats();
    req1_data = rand_poly();
    run_jobs(1, 1'b0, 1'b1, 100, ok);
    checks++;
    if (!ok || done1_cnt != 1) begin errors++; $display("FAIL midrun_next: d1=%0d required 1", done1_cnt); end
    pop_check("midrun_sb", 1'b0);
  endtask

  task automatic test_spurious_done();
    clear_stats();
    repeat (3) @(posedge clock); #1;
    force_done = 1'b1;
    repeat (3) @(posedge clock); #1;
    force_done = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (done0_cnt != 0 || done1_cnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL spurious_done: d0=%0d d1=%0d busy=%0b required 0/0/0", done0_cnt, done1_cnt, busy);
    end
    checks++;
    if (resp_data !== last_exp) begin errors++; $display("FAIL spurious_data: resp_data changed, required held"); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_stats();
    eng_en = 1'b0;
    req0_data = rand_poly();
`ifdef NTT_ARB_TIMEOUT_EN
    run_jobs(1, 1'b1, 1'b0, 100, ok);
    checks++;
    if (!ok || start_cycles != TMO || ntt_start !== 1'b0) begin
      errors++; $display("FAIL timeout_abort: ok=%0d start_cycles=%0d gap_start=%0b required 1/%0d/0",
                         ok, start_cycles, ntt_start, TMO);
    end
    pop_check("timeout_sb", 1'b1);
    clear_stats();
    eng_en = 1'b1;
    eng_lat = TMO;
    req0_data = rand_poly();
    run_jobs(1, 1'b1, 1'b0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL coincide_done: no done, required 1"); end
    pop_check("coincide_sb", 1'b0);
    eng_lat = 10;
`else
    req0_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clock); #1;
      ok = req0_ready;
    end
    @(posedge clock); #1;
    req0_valid = 1'b0;
    repeat (60) @(posedge clock); #1;
    checks++;
    if (!ok || busy !== 1'b1 || ntt_start !== 1'b1 || done0_cnt != 0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL wait_forever: busy=%0b start=%0b d0=%0d required 1/1/0", busy, ntt_start, done0_cnt);
    end
    eng_en = 1'b1;
    do_reset();
`endif
    eng_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_back_to_back();
    test_reset_mid_run();
    test_spurious_done();
    test_timeout();
    checks++;
    if (both_done != 0) begin errors++; $display("FAIL both_done: %0d cycles with both pulses, required 0", both_done); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
